ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: XLEN, 64, datapath width of result and store data.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 valid_i  input  1  upstream execute-stage result valid.
REQ-005 ready_o  output  1  stage can accept a beat this cycle.
REQ-006 alu_result_i  input  XLEN  ALU result (address or writeback value).
REQ-007 store_data_i  input  XLEN  rs2 value for stores.
REQ-008 rd_addr_i  input  5  destination register.
REQ-009 reg_write_i / mem_read_i / mem_write_i  input  1 each  control bits.
REQ-010 flush_i  input  1  discard all held and incoming beats.
REQ-011 valid_o  output  1  memory-stage payload valid.
REQ-012 ready_i  input  1  memory stage accepts payload.
REQ-013 alu_result_o, store_data_o  output  XLEN; rd_addr_o  output  5; reg_write_o, mem_read_o, mem_write_o  output  1 each.
REQ-014 fwd_valid_o  output  1; fwd_rd_o  output  5; fwd_data_o  output  XLEN: forwarding tap to the ALU operand muxes.

Function
REQ-015 Transfer in when valid_i && ready_o; transfer out when valid_o && ready_i.
REQ-016 Storage: main register (drives outputs) plus one skid register; states EMPTY, ONE (main only), FULL (main+skid).
REQ-017 ready_o shall be registered and equal to !FULL; it shall not depend combinationally on ready_i.
REQ-018 EMPTY: input beat -> main, go ONE; latency input-to-valid_o is one cycle.
REQ-019 ONE: in and out same cycle -> main replaced, stay ONE; in only -> skid, go FULL; out only -> go EMPTY.
REQ-020 FULL: out -> skid moves to main, go ONE; no input accepted (ready_o=0).
REQ-021 Outputs are taken directly from the main register; valid_o = (state != EMPTY).
REQ-022 At capture, reg_write shall be forced 0 when rd_addr_i == 0.
REQ-023 At capture, mem_read_i && mem_write_i both set shall be stored as mem_write only, mem_read cleared.
REQ-024 Payload outputs shall hold stable while valid_o && !ready_i.
REQ-025 fwd_valid_o = valid_o && reg_write_o && !mem_read_o; fwd_rd_o = rd_addr_o; fwd_data_o = alu_result_o.
REQ-026 flush_i: next state EMPTY, concurrent input beat dropped, flush takes priority over every transfer.
REQ-027 No combinational path from valid_i or payload inputs to any output.

Reset
REQ-028 rst_i high at a clock edge: state EMPTY, ready_o=1 the following cycle, valid_o=0, fwd_valid_o=0, all payload registers zero.
REQ-029 Reset mid-transfer shall discard held beats; rst_i has priority over flush_i and all transfers.

Structure
REQ-030 Shared package cpu_pkg holds XLEN default, REG_ADDR_W=5, and typedef struct ex_mem_payload_t (result, store data, rd, three control bits).
REQ-031 State encoding typedef ex_mem_state_e (EMPTY, ONE, FULL) is local to the module.
REQ-032 No sub-module; single module with main/skid registers and state register.

Verification
REQ-033 Reset, then idle -> valid_o=0, ready_o=1, all outputs 0.
REQ-034 ready_i=1, beats A(result=0x10,rd=5,rw=1), B(0x20,rd=6) back-to-back -> valid_o A then B on consecutive cycles, ready_o stays 1.
REQ-035 ready_i=0, beats A,B,C offered -> A,B held, ready_o=0 after B, C stalled; ready_i=1 -> A, B, C emitted in order, nothing lost or duplicated.
REQ-036 Beat rd=0, reg_write=1 -> reg_write_o=0, fwd_valid_o=0.
REQ-037 FULL state, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, flushed and incoming beats never appear.
REQ-038 Load beat (mem_read=1, rd=7) -> fwd_valid_o=0; ALU beat rd=7, result=0xDEAD -> fwd_valid_o=1, fwd_rd_o=7, fwd_data_o=0xDEAD.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline definitions.
//   XLEN_DEFAULT     default datapath width for result/store data
//   REG_ADDR_W       architectural register index width
//   ex_mem_payload_t payload carried from execute into the memory stage
package cpu_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_ADDR_W   = 5;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] result;
    logic [XLEN_DEFAULT-1:0] store_data;
    logic [REG_ADDR_W-1:0]   rd;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with a one-entry skid buffer.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i / ready_o            upstream handshake (ready_o is a flop)
//   alu_result_i, store_data_i   execute-stage result and rs2 value
//   rd_addr_i                    destination register
//   reg_write_i, mem_read_i,
//   mem_write_i                  control bits
//   flush_i                      drop every held and incoming beat
//   valid_o / ready_i            downstream handshake
//   alu_result_o, store_data_o,
//   rd_addr_o, reg_write_o,
//   mem_read_o, mem_write_o      payload, straight from the main register
//   fwd_valid_o, fwd_rd_o,
//   fwd_data_o                   forwarding tap for the ALU operand muxes
//
// state | meaning
// EMPTY | nothing held, outputs invalid
// ONE   | main register holds the beat on the outputs
// FULL  | main plus skid hold beats, input stalled
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       store_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       alu_result_o,
  output logic [XLEN-1:0]       store_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_rd_o,
  output logic [XLEN-1:0]       fwd_data_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ex_mem_state_e;

  ex_mem_state_e   state_q, state_d;
  ex_mem_payload_t main_q, skid_q, incoming;
  logic            ready_q;
  logic            in_fire, out_fire;
  logic            load_main_in, load_main_skid, load_skid;

  // Captured beat: x0 is never written, and a beat claiming both read and
  // write is treated as a store.
  always_comb begin
    incoming            = '0;
    incoming.result     = alu_result_i;
    incoming.store_data = store_data_i;
    incoming.rd         = rd_addr_i;
    incoming.reg_write  = reg_write_i && (rd_addr_i != '0);
    incoming.mem_read   = mem_read_i && !mem_write_i;
    incoming.mem_write  = mem_write_i;
  end

  // ready_q is low only in FULL, so in_fire never occurs in FULL.
  assign in_fire  = valid_i && ready_q;
  assign out_fire = (state_q != EMPTY) && ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      // Registered copy of "not FULL next cycle" keeps ready_o off ready_i.
      ready_q <= (state_d != FULL);
      if (load_main_in) begin
        main_q <= incoming;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= incoming;
      end
    end
  end

  assign ready_o      = ready_q;
  assign valid_o      = (state_q != EMPTY);
  assign alu_result_o = main_q.result;
  assign store_data_o = main_q.store_data;
  assign rd_addr_o    = main_q.rd;
  assign reg_write_o  = main_q.reg_write;
  assign mem_read_o   = main_q.mem_read;
  assign mem_write_o  = main_q.mem_write;

  // Loads are not forwarded here: their value arrives from memory later.
  assign fwd_valid_o  = valid_o && main_q.reg_write && !main_q.mem_read;
  assign fwd_rd_o     = main_q.rd;
  assign fwd_data_o   = main_q.result;

endmodule
